csa_tree_level_reg: RTL and testbench

- One registered level of a 3:2 carry-save compressor tree.
- Splits NUM_ELEMENTS equal-width input terms into consecutive triplets and reduces each triplet to a shifted-carry word and a sum word. Terms left over after the triplets pass through unchanged.
- All outputs are registered, so a multi-level reduction tree can be built by cascading levels.
- Used inside the modular-squaring datapath to reduce partial products before a final carry-propagate add.

---
 rtl/csa_tree_level_reg.sv | 81 ++++++++
 tb/tb_csa_tree_level_reg.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/csa_tree_level_reg.sv
// One registered level of a 3:2 carry-save compressor tree: triplets of terms
// reduce to (shifted carry, sum) pairs; leftover terms pass through.

module csa_3to2 #(
   parameter int unsigned W = 16
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] c_i,
   output logic [W-1:0] sum_c,
   output logic [W-1:0] carry_c
);

   logic [W-2:0] maj_lo;

   // Carry-out MSB would shift out of the word, so only the low W-1 majority bits exist.
   assign maj_lo  = (a_i[W-2:0] & b_i[W-2:0]) |
                    (a_i[W-2:0] & c_i[W-2:0]) |
                    (b_i[W-2:0] & c_i[W-2:0]);
   assign sum_c   = a_i ^ b_i ^ c_i;
   assign carry_c = {maj_lo, 1'b0};

endmodule

module csa_tree_level_reg #(
   parameter  int unsigned NUM_ELEMENTS = 9,
   parameter  int unsigned BIT_LEN      = 16,
   localparam int unsigned NUM_RESULTS  = (NUM_ELEMENTS / 3) * 2 + (NUM_ELEMENTS % 3)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [BIT_LEN-1:0] terms   [NUM_ELEMENTS],
   output logic               out_valid,
   output logic [BIT_LEN-1:0] results [NUM_RESULTS]
);

   localparam int unsigned NUM_GROUPS = NUM_ELEMENTS / 3;
   localparam int unsigned NUM_LEFT   = NUM_ELEMENTS % 3;

   logic [BIT_LEN-1:0] results_d [NUM_RESULTS];
   logic [BIT_LEN-1:0] results_q [NUM_RESULTS];
   logic               out_valid_q;

   for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_group
      csa_3to2 #(
         .W (BIT_LEN)
      ) u_csa (
         .a_i     (terms[3*g]),
         .b_i     (terms[3*g+1]),
         .c_i     (terms[3*g+2]),
         .sum_c   (results_d[2*g+1]),
         .carry_c (results_d[2*g])
      );
   end

   for (genvar l = 0; l < NUM_LEFT; l++) begin : g_left
      assign results_d[2*NUM_GROUPS+l] = terms[3*NUM_GROUPS+l];
   end

   // Results load only on valid input; valid flag is a plain 1-cycle delay.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         for (int j = 0; j < NUM_RESULTS; j++) begin
            results_q[j] <= '0;
         end
      end else begin
         out_valid_q <= in_valid;
         if (in_valid) begin
            for (int j = 0; j < NUM_RESULTS; j++) begin
               results_q[j] <= results_d[j];
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign results   = results_q;

endmodule

// File: tb/tb_csa_tree_level_reg.sv
// Randomized bench for csa_tree_level_reg: three instances (9, 4 and 5 terms)
// checked against a per-bit column-count reference model.

module tb_csa_tree_level_reg;

   localparam int unsigned W = 16;

   logic         clk;
   logic         rst_n;
   logic         iv9, iv4, iv5;
   logic         ov9, ov4, ov5;
   logic [W-1:0] t9 [9];
   logic [W-1:0] t4 [4];
   logic [W-1:0] t5 [5];
   logic [W-1:0] r9 [6];
   logic [W-1:0] r4 [3];
   logic [W-1:0] r5 [4];

   int n_vec;
   int n_err;

   logic [W-1:0] exp_r   [3][6];
   logic         exp_v   [3];
   logic [W-1:0] exp_sum [3];
   logic [W-1:0] act_r   [3][6];
   logic         act_v   [3];

   int ne_tab [3] = '{9, 4, 5};

   csa_tree_level_reg #(.NUM_ELEMENTS(9), .BIT_LEN(W)) u_d9 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv9), .terms(t9), .out_valid(ov9), .results(r9));
   csa_tree_level_reg #(.NUM_ELEMENTS(4), .BIT_LEN(W)) u_d4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .terms(t4), .out_valid(ov4), .results(r4));
   csa_tree_level_reg #(.NUM_ELEMENTS(5), .BIT_LEN(W)) u_d5 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv5), .terms(t5), .out_valid(ov5), .results(r5));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: each bit column of a triplet counts 0..3 ones; LSB is the sum, MSB the carry.
   function automatic void ref_reduce(input int ne, input logic [W-1:0] t [9],
                                      output logic [W-1:0] r [6]);
      int ng;
      int cnt;
      logic [W-1:0] sb, cb;
      ng = ne / 3;
      for (int j = 0; j < 6; j++) r[j] = '0;
      for (int g = 0; g < ng; g++) begin
         sb = '0;
         cb = '0;
         for (int b = 0; b < W; b++) begin
            cnt = int'(t[3*g][b]) + int'(t[3*g+1][b]) + int'(t[3*g+2][b]);
            sb[b] = (cnt % 2) == 1;
            if (b < W - 1) cb[b+1] = cnt >= 2;
         end
         r[2*g]   = cb;
         r[2*g+1] = sb;
      end
      for (int l = 0; l < ne % 3; l++) r[2*ng+l] = t[3*ng+l];
   endfunction

   function automatic logic [W-1:0] sum_terms(input int n, input logic [W-1:0] t [9]);
      logic [W-1:0] s = '0;
      for (int i = 0; i < n; i++) s = s + t[i];
      return s;
   endfunction

   task automatic gather_pad(input int k, output logic [W-1:0] p [9], output logic v);
      for (int i = 0; i < 9; i++) p[i] = '0;
      case (k)
         0: begin for (int i = 0; i < 9; i++) p[i] = t9[i]; v = iv9; end
         1: begin for (int i = 0; i < 4; i++) p[i] = t4[i]; v = iv4; end
         default: begin for (int i = 0; i < 5; i++) p[i] = t5[i]; v = iv5; end
      endcase
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         exp_v[k]   = 1'b0;
         exp_sum[k] = '0;
         for (int j = 0; j < 6; j++) exp_r[k][j] = '0;
      end
   endtask

   task automatic compare_all();
      logic [W-1:0] s;
      int nr;
      for (int j = 0; j < 6; j++) begin
         act_r[0][j] = r9[j];
         act_r[1][j] = (j < 3) ? r4[j] : '0;
         act_r[2][j] = (j < 4) ? r5[j] : '0;
      end
      act_v[0] = ov9; act_v[1] = ov4; act_v[2] = ov5;
      for (int k = 0; k < 3; k++) begin
         nr = (ne_tab[k] / 3) * 2 + ne_tab[k] % 3;
         check($sformatf("ne%0d_out_valid", ne_tab[k]), 32'(act_v[k]), 32'(exp_v[k]));
         s = '0;
         for (int j = 0; j < nr; j++) begin
            check($sformatf("ne%0d_results[%0d]", ne_tab[k], j), 32'(act_r[k][j]), 32'(exp_r[k][j]));
            s = s + act_r[k][j];
         end
         if (exp_v[k]) check($sformatf("ne%0d_sum_invariant", ne_tab[k]), 32'(s), 32'(exp_sum[k]));
      end
   endtask

   // One clock: model follows the DUT edge, then outputs are compared just after it.
   task automatic tick();
      logic [W-1:0] p [9];
      logic [W-1:0] r [6];
      logic v;
      @(posedge clk);
      if (rst_n) begin
         for (int k = 0; k < 3; k++) begin
            gather_pad(k, p, v);
            exp_v[k] = v;
            if (v) begin
               ref_reduce(ne_tab[k], p, r);
               for (int j = 0; j < 6; j++) exp_r[k][j] = r[j];
               exp_sum[k] = sum_terms(ne_tab[k], p);
            end
         end
      end
      #1;
      compare_all();
   endtask

   task automatic clear_inputs();
      iv9 = 1'b0; iv4 = 1'b0; iv5 = 1'b0;
      for (int i = 0; i < 9; i++) t9[i] = '0;
      for (int i = 0; i < 4; i++) t4[i] = '0;
      for (int i = 0; i < 5; i++) t5[i] = '0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      #2;
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Directed vectors on all three widths at once.
      @(negedge clk);
      t9[0] = 16'd3; t9[1] = 16'd5; t9[2] = 16'd6;
      t4[0] = 16'd1; t4[1] = 16'd2; t4[2] = 16'd4; t4[3] = 16'h1234;
      t5[0] = 16'd7; t5[1] = 16'd7; t5[2] = 16'd7; t5[3] = 16'hAAAA; t5[4] = 16'h5555;
      iv9 = 1'b1; iv4 = 1'b1; iv5 = 1'b1;
      tick();
      check("dir9_valid", 32'(ov9), 32'd1);
      check("dir9_r0", 32'(r9[0]), 32'd14);
      check("dir9_r1", 32'(r9[1]), 32'd0);
      check("dir9_r5", 32'(r9[5]), 32'd0);
      check("dir4_r0", 32'(r4[0]), 32'd0);
      check("dir4_r1", 32'(r4[1]), 32'd7);
      check("dir4_r2", 32'(r4[2]), 32'h1234);
      check("dir5_r0", 32'(r5[0]), 32'd14);
      check("dir5_r1", 32'(r5[1]), 32'd7);
      check("dir5_r2", 32'(r5[2]), 32'hAAAA);
      check("dir5_r3", 32'(r5[3]), 32'h5555);

      @(negedge clk);
      t9[0] = 16'hFFFF; t9[1] = 16'hFFFF; t9[2] = 16'hFFFF;
      tick();
      check("ovf_r0", 32'(r9[0]), 32'hFFFE);
      check("ovf_r1", 32'(r9[1]), 32'hFFFF);
      check("ovf_sum", 32'(16'(r9[0] + r9[1])), 32'hFFFD);

      // Asynchronous reset between edges while out_valid is high.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      check("async_rst_valid", 32'(ov9), 32'd0);
      check("async_rst_r0", 32'(r9[0]), 32'd0);
      #1;
      rst_n = 1'b1;
      clear_inputs();
      tick();

      // Random streaming with random valid.
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         iv9 = ($urandom_range(0, 3) != 0);
         iv4 = ($urandom_range(0, 1) != 0);
         iv5 = ($urandom_range(0, 4) == 0);
         for (int i = 0; i < 9; i++) t9[i] = W'($urandom);
         for (int i = 0; i < 4; i++) t4[i] = W'($urandom);
         for (int i = 0; i < 5; i++) t5[i] = W'($urandom);
         if (c % 97 == 0) for (int i = 0; i < 9; i++) t9[i] = 16'hFFFF;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
